// File: rtl/rx_pkt_filter.sv
// Store-and-forward RX packet filter: commits good frames, rolls back bad/oversize ones.
// Optional per-packet statistics counters are built when RX_PKT_FILTER_STATS_EN is defined.
module rx_pkt_filter #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH     = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXI_DATA_WIDTH-1:0]   s_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_tstrb,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  input  logic                        s_err,
  output logic [AXI_DATA_WIDTH-1:0]   m_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_tstrb,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready
`ifdef RX_PKT_FILTER_STATS_EN
  ,
  output logic [31:0]                 good_pkt_cnt,
  output logic [31:0]                 bad_pkt_cnt,
  output logic [31:0]                 oversize_cnt
`endif
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = ADDR_WIDTH + 1;

  typedef enum logic [0:0] {StAccept, StDrop} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q;

  logic [STRB_W+AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic                             last_flag [DEPTH];

  logic                  full, avail, strobeless, oversize;
  logic [PTR_W-1:0]      wr_ptr_inc, wr_ptr_dec;
  logic                  mem_we, flag_we, flag_val;
  logic [ADDR_WIDTH-1:0] flag_addr;
  logic                  good_evt, bad_evt, over_evt;

  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign wr_ptr_dec = wr_ptr_q - 1'b1;
  assign full       = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  assign avail      = rd_ptr_q != commit_ptr_q;
  assign strobeless = s_tlast && (s_tstrb == '0);
  // Buffer is entirely occupied by the packet being received: it can never fit.
  assign oversize   = full && s_tvalid && (commit_ptr_q == rd_ptr_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    s_tready     = 1'b0;
    mem_we       = 1'b0;
    flag_we      = 1'b0;
    flag_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
    flag_val     = s_tlast;
    good_evt     = 1'b0;
    bad_evt      = 1'b0;
    over_evt     = 1'b0;
    case (state_q)
      StAccept: begin
        if (s_tvalid && strobeless) begin
          // Terminator carries no data: retro-mark the previous beat as last.
          s_tready = 1'b1;
          if ((wr_ptr_q != commit_ptr_q) && !s_err) begin
            flag_we      = 1'b1;
            flag_addr    = wr_ptr_dec[ADDR_WIDTH-1:0];
            flag_val     = 1'b1;
            commit_ptr_d = wr_ptr_q;
            good_evt     = 1'b1;
          end else begin
            wr_ptr_d = commit_ptr_q;
            bad_evt  = 1'b1;
          end
        end else if (oversize) begin
          s_tready = 1'b1;
          wr_ptr_d = commit_ptr_q;
          over_evt = 1'b1;
          // A last beat here already ends the packet, so there is nothing left to sink.
          if (!s_tlast) state_d = StDrop;
        end else begin
          s_tready = !full;
          if (s_tvalid && !full) begin
            mem_we  = 1'b1;
            flag_we = 1'b1;
            if (!s_tlast) begin
              wr_ptr_d = wr_ptr_inc;
            end else if (!s_err) begin
              wr_ptr_d     = wr_ptr_inc;
              commit_ptr_d = wr_ptr_inc;
              good_evt     = 1'b1;
            end else begin
              wr_ptr_d = commit_ptr_q;
              bad_evt  = 1'b1;
            end
          end
        end
      end
      StDrop: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = StAccept;
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StAccept;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_tstrb, s_tdata};
    if (flag_we) last_flag[flag_addr] <= flag_val;
  end

  // Read side: RAM read register (pend) feeding a single output register.
  logic                             pend_q;
  logic [STRB_W+AXI_DATA_WIDTH-1:0] ram_q;
  logic                             ram_last_q;
  logic                             out_valid_q, out_last_q;
  logic [STRB_W+AXI_DATA_WIDTH-1:0] out_q;
  logic                             move, fetch;

  assign move  = pend_q && (!out_valid_q || m_tready);
  assign fetch = avail && (!pend_q || move);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      ram_q       <= '0;
      ram_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      if (fetch) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        ram_q      <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        ram_last_q <= last_flag[rd_ptr_q[ADDR_WIDTH-1:0]];
        pend_q     <= 1'b1;
      end else if (move) begin
        pend_q <= 1'b0;
      end
      if (move) begin
        out_valid_q <= 1'b1;
        out_q       <= ram_q;
        out_last_q  <= ram_last_q;
      end else if (m_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_tvalid = out_valid_q;
  assign m_tlast  = out_last_q;
  assign m_tdata  = out_q[AXI_DATA_WIDTH-1:0];
  assign m_tstrb  = out_q[STRB_W+AXI_DATA_WIDTH-1:AXI_DATA_WIDTH];

`ifdef RX_PKT_FILTER_STATS_EN
  logic [31:0] good_q, bad_q, over_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
      over_q <= '0;
    end else begin
      if (good_evt && (good_q != '1)) good_q <= good_q + 1'b1;
      if (bad_evt && (bad_q != '1))   bad_q  <= bad_q + 1'b1;
      if (over_evt && (over_q != '1)) over_q <= over_q + 1'b1;
    end
  end

  assign good_pkt_cnt = good_q;
  assign bad_pkt_cnt  = bad_q;
  assign oversize_cnt = over_q;
`endif

endmodule

// File: tb/tb_rx_pkt_filter.sv
// Directed bench for rx_pkt_filter with a 16-entry buffer; checks output beats, pointers and
// (when RX_PKT_FILTER_STATS_EN is defined) the statistics counters.
module tb_rx_pkt_filter;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic        s_tvalid, s_tlast, s_tready, s_err;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        m_tvalid, m_tlast, m_tready;
`ifdef RX_PKT_FILTER_STATS_EN
  logic [31:0] good_pkt_cnt, bad_pkt_cnt, oversize_cnt;
`endif

  rx_pkt_filter #(.AXI_DATA_WIDTH(64), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .s_err    (s_err),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
`ifdef RX_PKT_FILTER_STATS_EN
    ,
    .good_pkt_cnt (good_pkt_cnt),
    .bad_pkt_cnt  (bad_pkt_cnt),
    .oversize_cnt (oversize_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [72:0] rx_q[$];  // {tlast, tstrb, tdata}

  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tstrb, m_tdata});
  end

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] st, input logic l, input logic e);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    s_err    = e;
  endtask

  task automatic wait_accept(input string tag, output int stalls);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      if (stalls >= 50) begin
        check({tag, "_accept_timeout"}, s_tready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] st, input logic l, input logic e,
                      output int stalls);
    drive(d, st, l, e);
    wait_accept("send", stalls);
  endtask

  task automatic send_pkt(input logic [63:0] base, input int n, input logic [7:0] last_strb,
                          input logic e, output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send(base + 64'(i), (i == n - 1) ? last_strb : 8'hFF, i == n - 1, e && (i == n - 1), st);
      stalls += st;
    end
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] d, input logic [7:0] st,
                             input logic l);
    logic [72:0] got;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
    check(tag, got, {l, st, d});
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int st;

  initial begin
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    s_err    = 1'b0;
    m_tready = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_m_tstrb", m_tstrb, 8'h0);
    check("rst_s_tready", s_tready, 1'b1);
    check("rst_wr_ptr", dut.wr_ptr_q, 0);
    check("rst_commit_ptr", dut.commit_ptr_q, 0);
    check("rst_rd_ptr", dut.rd_ptr_q, 0);

    // Good 4-beat packet, m_tvalid within 2 cycles of the commit
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_pkt(64'h1000, 4, 8'h0F, 1'b0, st);
    idle(2);
    check("good_latency", m_tvalid, 1'b1);
    idle(10);
    check("good_count", rx_q.size(), 4);
    expect_beat("good_b0", 64'h1000, 8'hFF, 1'b0);
    expect_beat("good_b1", 64'h1001, 8'hFF, 1'b0);
    expect_beat("good_b2", 64'h1002, 8'hFF, 1'b0);
    expect_beat("good_b3", 64'h1003, 8'h0F, 1'b1);

    // Bad packet followed immediately by a good one
    do_reset();
    m_tready = 1'b1;
    send_pkt(64'h2000, 3, 8'hFF, 1'b1, st);
    send_pkt(64'h3000, 2, 8'hFF, 1'b0, st);
    idle(10);
    check("badgood_count", rx_q.size(), 2);
    expect_beat("badgood_b0", 64'h3000, 8'hFF, 1'b0);
    expect_beat("badgood_b1", 64'h3001, 8'hFF, 1'b1);
    check("badgood_commit_ptr", dut.commit_ptr_q, 2);
`ifdef RX_PKT_FILTER_STATS_EN
    check("badgood_good_cnt", good_pkt_cnt, 1);
    check("badgood_bad_cnt", bad_pkt_cnt, 1);
`endif

    // Strobe-less terminator, then an empty terminator-only packet
    do_reset();
    m_tready = 1'b1;
    send(64'h4000, 8'hFF, 1'b0, 1'b0, st);
    send(64'h4001, 8'hFF, 1'b0, 1'b0, st);
    send(64'h4002, 8'h00, 1'b1, 1'b0, st);
    idle(10);
    check("term_count", rx_q.size(), 2);
    expect_beat("term_b0", 64'h4000, 8'hFF, 1'b0);
    expect_beat("term_b1", 64'h4001, 8'hFF, 1'b1);
    send(64'h4003, 8'h00, 1'b1, 1'b0, st);
    idle(10);
    check("empty_count", rx_q.size(), 0);
    check("empty_wr_ptr", dut.wr_ptr_q, 2);
    check("empty_commit_ptr", dut.commit_ptr_q, 2);
`ifdef RX_PKT_FILTER_STATS_EN
    check("term_good_cnt", good_pkt_cnt, 1);
    check("term_bad_cnt", bad_pkt_cnt, 1);
`endif

    // Oversize 20-beat packet into a 16-entry buffer, then a 3-beat packet
    do_reset();
    m_tready = 1'b0;
    send_pkt(64'h5000, 20, 8'hFF, 1'b0, st);
    check("over_stalls", st, 0);
    check("over_wr_ptr", dut.wr_ptr_q, 0);
    send_pkt(64'h6000, 3, 8'h03, 1'b0, st);
    idle(5);
    check("over_held", rx_q.size(), 0);
    m_tready = 1'b1;
    idle(10);
    check("over_count", rx_q.size(), 3);
    expect_beat("over_b0", 64'h6000, 8'hFF, 1'b0);
    expect_beat("over_b1", 64'h6001, 8'hFF, 1'b0);
    expect_beat("over_b2", 64'h6002, 8'h03, 1'b1);
`ifdef RX_PKT_FILTER_STATS_EN
    check("over_oversize_cnt", oversize_cnt, 1);
`endif

    // Backpressure: fill to full, stall, then drain in order
    do_reset();
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(64'hB000 + 64'(p * 16), 4, 8'hFF, 1'b0, st);
      check("bp_fill_stalls", st, 0);
    end
    send(64'hB040, 8'hFF, 1'b0, 1'b0, st);
    send(64'hB041, 8'hFF, 1'b0, 1'b0, st);
    drive(64'hB042, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_s_tready_low", s_tready, 1'b0);
    check("bp_no_output", rx_q.size(), 0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_accept("bp_resume", st);
    send(64'hB043, 8'hFF, 1'b1, 1'b0, st);
    idle(30);
    check("bp_count", rx_q.size(), 20);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) begin
        expect_beat($sformatf("bp_p%0d_b%0d", p, i), 64'hB000 + 64'(p * 16 + i), 8'hFF, i == 3);
      end
    end

    // Reset in the middle of a packet
    m_tready = 1'b1;
    send(64'h7000, 8'hFF, 1'b0, 1'b0, st);
    send(64'h7001, 8'hFF, 1'b0, 1'b0, st);
    do_reset();
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_wr_ptr", dut.wr_ptr_q, 0);
    check("midrst_commit_ptr", dut.commit_ptr_q, 0);
    check("midrst_rd_ptr", dut.rd_ptr_q, 0);
    @(posedge clk);
    #1;
    send(64'h00AB, 8'h01, 1'b1, 1'b0, st);
    idle(10);
    check("midrst_count", rx_q.size(), 1);
    expect_beat("midrst_b0", 64'h00AB, 8'h01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rx_pkt_filter.md
Name: rx_pkt_filter

Overview:
Store-and-forward packet buffer directly downstream of the 10G RX MAC-to-AXI converter, in the `clk` domain. It accepts the converter's AXI4-Stream output together with its per-packet `err_tvalid` flag. It holds each packet until its last beat arrives, then either commits it or discards it. Only complete, good packets are presented to the downstream datapath.

Parameters:
- AXI_DATA_WIDTH, 64, stream data width. Only 64 is supported.
- ADDR_WIDTH, 9, log2 of buffer depth in beats (DEPTH = 512).

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_tdata  in  AXI_DATA_WIDTH  input beat data.
- s_tstrb  in  AXI_DATA_WIDTH/8  input byte strobes.
- s_tvalid  in  1  input beat valid.
- s_tlast  in  1  input end of packet.
- s_tready  out  1  input beat accepted.
- s_err  in  1  bad-frame flag; meaningful only on the s_tlast beat.
- m_tdata  out  AXI_DATA_WIDTH  output data.
- m_tstrb  out  AXI_DATA_WIDTH/8  output strobes.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet.
- m_tready  in  1  downstream ready.

Behaviour:
- **Storage:** DEPTH entries of {tlast, tstrb, tdata}. The tlast bit is held in a separately writable flag array.
- **Pointers:** three pointers, each ADDR_WIDTH+1 bits with the MSB as wrap bit: wr_ptr (speculative), commit_ptr, rd_ptr.
  - full = (wr_ptr − rd_ptr) == DEPTH.
  - avail = (rd_ptr != commit_ptr).
- **Handshake:** a beat transfers when s_tvalid & s_tready, or when m_tvalid & m_tready. Outputs hold stable while m_tvalid & ~m_tready.
- **Write FSM, state ACCEPT:**
  - s_tready = ~full.
  - A non-last beat is written at wr_ptr, then wr_ptr+1.
- **Write FSM, state DROP:**
  - s_tready = 1; every beat is sunk.
  - On the tlast beat, return to ACCEPT. Nothing is committed.
- **Oversize:** if full, s_tvalid, and commit_ptr == rd_ptr (the buffer holds only the current packet):
  - wr_ptr <= commit_ptr.
  - Go to DROP.
  - The same cycle asserts s_tready = 1 and consumes the beat.
- **Last beat, s_tstrb != 0:** the beat is written with tlast = 1.
  - If s_err = 0: commit_ptr <= wr_ptr+1 and wr_ptr <= wr_ptr+1.
  - If s_err = 1: wr_ptr <= commit_ptr.
- **Last beat, s_tstrb == 0 (strobe-less terminator):**
  - The beat is not stored; s_tready = 1 regardless of full.
  - If wr_ptr != commit_ptr and s_err = 0: set the tlast flag at wr_ptr−1 and set commit_ptr <= wr_ptr.
  - If wr_ptr == commit_ptr (empty packet), or s_err = 1: wr_ptr <= commit_ptr.
- **Read side:**
  - One-entry registered output stage, prefetched from the RAM (1-cycle read latency).
  - m_tvalid rises no later than 2 cycles after the commit cycle.
  - Sustains 1 beat per cycle while m_tready = 1 and avail.
  - rd_ptr advances on each RAM fetch.
- **Simultaneous events:** commit, read and rollback in the same cycle are legal. A rollback never moves wr_ptr below commit_ptr, and never touches committed data.
- **Reset (any time, including mid-packet):**
  - All three pointers go to 0; FSM goes to ACCEPT.
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, m_tstrb = 0.
  - s_tready is 1 in the first cycle after reset.
  - A partially received packet is lost. Input beats after reset that are not preceded by a packet start are accepted as a new packet.
- **Ordering:** packets leave in arrival order. No beat of a discarded packet ever appears on m_*.

Optional Feature:
- **Macro:** RX_PKT_FILTER_STATS_EN.
- **When defined:**
  - Adds outputs good_pkt_cnt, bad_pkt_cnt, oversize_cnt, each 32 bits.
  - good_pkt_cnt increments on a commit.
  - bad_pkt_cnt increments on an s_err rollback. An empty strobe-less packet counts here too.
  - oversize_cnt increments on entry to DROP.
  - Counters are saturating, cleared by reset, and update the cycle after the event.
- **When undefined:** the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Good packet: 4 beats, s_tstrb FF,FF,FF,0F, s_err = 0, m_tready = 1. Expect m_* to carry the same 4 beats with m_tlast on beat 4, and m_tvalid within 2 cycles of the input tlast.
- Bad then good: 3-beat packet with s_err = 1 on its tlast, followed immediately by a 2-beat good packet. Expect only the 2-beat packet on the output; commit_ptr = 2.
- Strobe-less terminator: 2 beats FF,FF, then tlast with s_tstrb = 00 and s_err = 0. Expect 2 output beats with m_tlast on the second. Tlast with s_tstrb = 00 on an empty packet gives no output.
- Oversize: ADDR_WIDTH = 4, a 20-beat packet, m_tready = 0. Expect the packet dropped, s_tready never stalling, and a following 3-beat packet output intact. With STATS_EN: oversize_cnt = 1.
- Backpressure: fill with committed packets until full, then hold m_tready = 0. Expect s_tready = 0 and no data loss. Release m_tready: all packets drain in order.
- Reset mid-packet: assert reset after 2 beats of a packet. Expect m_tvalid = 0 and pointers at 0. A subsequent 1-beat good packet (tstrb 01) is output correctly.
